// File: rtl/reg_file_param.sv
// reg_file_param: parametrised decode-stage register file with zero register,
// stack-pointer preset and post-reset clear engine. Write-through forwarding
// is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_param #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned NUM_RD   = 2,
  parameter int unsigned SP_IDX   = 29,
  parameter int unsigned SP_INIT  = 10000,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regWrite,
  input  logic [ADDR_W-1:0]        writeReg,
  input  logic [DATA_W-1:0]        writeData,
  input  logic [NUM_RD*ADDR_W-1:0] readReg,
  output logic [NUM_RD*DATA_W-1:0] readData,
  output logic                     init_busy
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_idx;
  logic [ADDR_W-1:0] w_clr_idx_nxt;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_clr_last;
  logic              w_wr_en;

  assign w_clr_last = (r_clr_idx == ADDR_W'(DEPTH - 1));
  assign init_busy  = (r_state == CLEAR);

  // State and clear-counter register; the only flops with reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= CLEAR;
      r_clr_idx <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_idx <= w_clr_idx_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      CLEAR: begin
        w_clr_idx_nxt = r_clr_idx + ADDR_W'(1);
        if (w_clr_last) begin
          w_state_nxt = READY;
        end
      end
      default: ;
    endcase
  end

  assign w_wr_en = (r_state == READY) && regWrite &&
                   !(ZERO_REG && (writeReg == '0));

  // Array has no reset: the clear engine scrubs it, then write-back owns it.
  always_ff @(posedge clk) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_idx] <= (r_clr_idx == ADDR_W'(SP_IDX)) ? DATA_W'(SP_INIT) : '0;
    end else if (w_wr_en) begin
      r_mem[writeReg] <= writeData;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] w_idx;
    logic [DATA_W-1:0] w_data;

    assign w_idx = readReg[k*ADDR_W +: ADDR_W];

    // Zero-latency read; forced to zero while clearing and for the zero register.
    always_comb begin
      w_data = r_mem[w_idx];
`ifdef REG_FILE_BYPASS_EN
      if (regWrite && (writeReg == w_idx)) begin
        w_data = writeData;
      end
`endif
      if ((r_state == CLEAR) || (ZERO_REG && (w_idx == '0))) begin
        w_data = '0;
      end
    end

    assign readData[k*DATA_W +: DATA_W] = w_data;
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Self-checking bench for reg_file_param: default instance plus a small
// 16-bit / 8-entry / 3-port variant, vector table, random model comparison.
module tb_reg_file_param;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        we = 1'b0;
  logic [4:0]  waddr = '0;
  logic [31:0] wdata = '0;
  logic [9:0]  rreg = '0;
  logic [63:0] rdata;
  logic        busy;

  logic        rst_s = 1'b0;
  logic        we_s = 1'b0;
  logic [2:0]  waddr_s = '0;
  logic [15:0] wdata_s = '0;
  logic [8:0]  rreg_s = '0;
  logic [47:0] rdata_s;
  logic        busy_s;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] m [32];

  always #5 clk = ~clk;

  reg_file_param u_dut (
    .clk(clk), .rst(rst), .regWrite(we), .writeReg(waddr), .writeData(wdata),
    .readReg(rreg), .readData(rdata), .init_busy(busy)
  );

  reg_file_param #(
    .DATA_W(16), .ADDR_W(3), .NUM_RD(3), .SP_IDX(7), .SP_INIT(32'h1234), .ZERO_REG(1'b1)
  ) u_small (
    .clk(clk), .rst(rst_s), .regWrite(we_s), .writeReg(waddr_s), .writeData(wdata_s),
    .readReg(rreg_s), .readData(rdata_s), .init_busy(busy_s)
  );

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r0;
    logic [4:0]  r1;
    logic [31:0] e0;
    logic [31:0] e1;
  } vec_t;

  vec_t vt [9];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 32; i++) m[i] = 32'h0;
    m[29] = 32'd10000;
  endtask

  task automatic model_write(input logic w, input logic [4:0] a, input logic [31:0] d);
    if (w && (a != 5'd0)) m[a] = d;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] idx, input logic w,
                                         input logic [4:0] a, input logic [31:0] d);
    if (idx == 5'd0) return 32'h0;
    if (BYP && w && (idx == a)) return d;
    return m[idx];
  endfunction

  // Counts posedges from reset release until init_busy drops; reads stay 0 meanwhile.
  task automatic wait_clear(output int cnt);
    cnt = 0;
    rreg = {5'd29, 5'd29};
    for (int c = 0; c < 100; c++) begin
      tick();
      cnt++;
      if (!busy) break;
      check("read_during_clear", rdata, 64'h0);
    end
  endtask

  initial begin
    int cnt;
    logic [4:0] r0, r1;

    vt[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd7, BYP ? 32'hDEADBEEF : 32'h0, 32'h0};
    vt[1] = '{1'b1, 5'd7, 32'h12345678, 5'd5, 5'd7, 32'hDEADBEEF, BYP ? 32'h12345678 : 32'h0};
    vt[2] = '{1'b0, 5'd0, 32'h0, 5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678};
    vt[3] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 32'h12345678, 32'h12345678};
    vt[4] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd29, 32'h0, 32'd10000};
    vt[5] = '{1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 32'h0, 32'h0};
    vt[6] = '{1'b1, 5'd9, 32'h11, 5'd9, 5'd5, BYP ? 32'h11 : 32'h0, 32'hDEADBEEF};
    vt[7] = '{1'b1, 5'd9, 32'h22, 5'd9, 5'd9, BYP ? 32'h22 : 32'h11, BYP ? 32'h22 : 32'h11};
    vt[8] = '{1'b0, 5'd0, 32'h0, 5'd9, 5'd29, 32'h22, 32'd10000};

    rst = 1'b1;
    rst_s = 1'b1;
    rreg = {5'd29, 5'd1};
    repeat (3) begin
      tick();
      check("reset_busy", 64'(busy), 64'h1);
      check("reset_read", rdata, 64'h0);
    end
    rst = 1'b0;
    wait_clear(cnt);
    check("clear_cycles", 64'(cnt), 64'd32);
    model_clear();

    for (int i = 0; i < 32; i++) begin
      rreg = {5'(i), 5'(i)};
      #1;
      check("post_clear_p0", 64'(rdata[31:0]), 64'(exp_rd(5'(i), 1'b0, 5'd0, 32'h0)));
      check("post_clear_p1", 64'(rdata[63:32]), 64'(i == 29 ? 32'd10000 : 32'h0));
    end

    for (int i = 0; i < 9; i++) begin
      we = vt[i].we; waddr = vt[i].wa; wdata = vt[i].wd;
      rreg = {vt[i].r1, vt[i].r0};
      #1;
      check($sformatf("vec%0d_p0", i), 64'(rdata[31:0]), 64'(vt[i].e0));
      check($sformatf("vec%0d_p1", i), 64'(rdata[63:32]), 64'(vt[i].e1));
      tick();
      model_write(vt[i].we, vt[i].wa, vt[i].wd);
    end
    we = 1'b0;

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom_range(0, 1));
      waddr = 5'($urandom);
      wdata = $urandom;
      r0 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom);
      rreg = {r1, r0};
      #1;
      check("rand_p0", 64'(rdata[31:0]), 64'(exp_rd(r0, we, waddr, wdata)));
      check("rand_p1", 64'(rdata[63:32]), 64'(exp_rd(r1, we, waddr, wdata)));
      tick();
      model_write(we, waddr, wdata);
    end
    we = 1'b0;

    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      we = (c == 2); waddr = 5'd3; wdata = 32'hAA;
    end
    we = 1'b0;
    check("busy_before_midrst", 64'(busy), 64'h1);
    rst = 1'b1;
    repeat (2) begin
      tick();
      check("busy_midrst", 64'(busy), 64'h1);
    end
    rst = 1'b0;
    wait_clear(cnt);
    check("clear_cycles_restart", 64'(cnt), 64'd32);
    model_clear();
    rreg = {5'd5, 5'd3};
    #1;
    check("r3_dropped", 64'(rdata[31:0]), 64'h0);
    check("r5_scrubbed", 64'(rdata[63:32]), 64'h0);
    rreg = {5'd29, 5'd29};
    #1;
    check("sp_after_restart", rdata, {32'd10000, 32'd10000});

    rst_s = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      cnt++;
      if (!busy_s) break;
    end
    check("small_clear_cycles", 64'(cnt), 64'd8);
    for (int i = 0; i < 8; i++) begin
      rreg_s = {3'(7 - i), 3'(i), 3'(i)};
      #1;
      check("small_clear_p0", 64'(rdata_s[15:0]), 64'(i == 7 ? 16'h1234 : 16'h0));
      check("small_clear_p2", 64'(rdata_s[47:32]), 64'(i == 0 ? 16'h1234 : 16'h0));
    end
    we_s = 1'b1; waddr_s = 3'd4; wdata_s = 16'hBEEF;
    rreg_s = {3'd0, 3'd7, 3'd4};
    #1;
    check("small_wr_cycle_p0", 64'(rdata_s[15:0]), 64'(BYP ? 16'hBEEF : 16'h0));
    tick();
    we_s = 1'b0;
    #1;
    check("small_read", 64'(rdata_s), {16'h0, 16'h0, 16'h0000, 16'h1234, 16'hBEEF});

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_file_param.md
Name: reg_file_param

Overview:
Parametrised successor to the single-cycle datapath register file: generic data width, depth and read-port count.
- Hardware zero register.
- Configurable stack-pointer preset.
- Sequential post-reset clear engine that scrubs every entry, one per clock.
- Sits in the decode stage between instruction decode and the ALU operand muxes; written from write-back.

Parameters:
DATA_W, 32, data width in bits
ADDR_W, 5, register index width; DEPTH = 2**ADDR_W entries
NUM_RD, 2, number of independent read ports (1..4)
SP_IDX, 29, index preloaded with SP_INIT during clear
SP_INIT, 10000, value written to SP_IDX by the clear engine (truncated to DATA_W)
ZERO_REG, 1, 1 = index 0 reads 0 and ignores writes; 0 = index 0 is an ordinary register

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-high reset
regWrite  input  1  write enable, sampled at posedge clk
writeReg  input  ADDR_W  write index
writeData  input  DATA_W  write data
readReg  input  NUM_RD*ADDR_W  read indices; port k occupies bits [k*ADDR_W +: ADDR_W]
readData  output  NUM_RD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W]
init_busy  output  1  high while the clear engine is running; writes are dropped

Behaviour:
State machine: two states, CLEAR and READY, plus an ADDR_W-bit clear counter clr_idx.

While rst is high (asynchronous):
- state=CLEAR, clr_idx=0, init_busy=1.
- All readData ports = 0.
- Array contents are not modified asynchronously.

CLEAR, on each posedge:
- mem[clr_idx] <= (clr_idx==SP_IDX) ? SP_INIT : 0.
- clr_idx increments.
- When clr_idx==DEPTH-1 the write happens, then: state -> READY, clr_idx wraps to 0, init_busy -> 0.
- Total: exactly DEPTH cycles from the first posedge after rst falls until init_busy=0.
- rst reasserted mid-clear: restart from index 0; clearing resumes after release.

During CLEAR:
- regWrite is ignored. The write is dropped, not queued.
- Every readData port = 0.

READY:
- posedge with regWrite=1 writes mem[writeReg] <= writeData.
- If ZERO_REG=1 and writeReg==0, the write is dropped.

Reads (READY):
- Combinational, zero latency, all NUM_RD ports independent.
- Duplicate indices across ports are legal and return identical data.
- ZERO_REG=1: index 0 always returns 0, including the bypass case below.

Simultaneous read/write of the same index in one cycle: result depends on the bypass option (see Optional Feature). The array holds writeData after the edge in all cases.

Width rules: no sign extension; SP_INIT truncated to its low DATA_W bits.

The state register and counter are the only flops with reset. Array entries have no reset; the clear engine initialises them.

Optional Feature:
Macro: REG_FILE_BYPASS_EN
- Defined: write-through forwarding. In READY, if regWrite=1 and readReg port k == writeReg (and not the ZERO_REG-suppressed index 0), readData port k = writeData in the same cycle, before the edge. Removes the write-back->decode hazard.
- Not defined: readData port k shows the old array value until after the posedge. Next cycle it shows writeData.
- No port or parameter changes either way.

Test Plan:
1. Reset then clear, defaults: pulse rst for 3 cycles, release. init_busy=1 for exactly 32 posedges, then 0. Read r29 -> 10000; read r1..r28, r30, r31 -> 0.
2. Write/read across ports: write r5=0xDEADBEEF, r7=0x12345678 in consecutive cycles. Next cycle set readReg port0=5, port1=7 -> 0xDEADBEEF, 0x12345678. Set both ports=7 -> both 0x12345678.
3. Zero register: write r0=0xFFFFFFFF with regWrite=1 -> port0 reads 0 that cycle and the next; with REG_FILE_BYPASS_EN defined, still 0 in the write cycle.
4. Same-index read/write: r9 holds 0x11, write r9=0x22 while port0 reads 9.
   - Bypass macro defined: 0x22 before the edge.
   - Not defined: 0x11 before the edge, 0x22 after.
5. Write during clear and reset mid-clear:
   - Assert regWrite r3=0xAA at clear cycle 2 -> after READY, r3 reads 0.
   - Assert rst at clear cycle 10 -> init_busy stays 1; after release, a full 32-cycle clear completes.
6. Parameter variant: DATA_W=16, ADDR_W=3, NUM_RD=3, SP_IDX=7, SP_INIT=0x1234.
   - Clear takes 8 cycles; r7=0x1234.
   - Write r4=0xBEEF; ports 0/1/2 read 4/7/0 -> 0xBEEF, 0x1234, 0x0000.
